tournament_branch_predictor: RTL and testbench

- Tournament (local + gshare + chooser) direction predictor for the 5-stage RV32I pipeline.
- Fetch side: looks up the fetch PC combinationally and produces the prediction and table indices. IF/ID captures these, and ID/EX carries them to EX.
- Resolve side: consumes the resolved-branch fields out of ID/EX/EX and trains the tables.
- After reset, runs a clear FSM that initialises all tables before predicting.

---
 rtl/tournament_branch_predictor.sv | 164 ++++++++++++++++
 tb/tb_tournament_branch_predictor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_branch_predictor.sv
// Tournament direction predictor: local table, gshare table and a chooser, all 2-bit counters.
// Optional BP_STATS_EN macro adds branch / mispredict counters.
module tournament_branch_predictor #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      fetch_pc,
    output logic             l_p_outcome,
    output logic             g_p_outcome,
    output logic             p_outcome,
    output logic [IDX_W-1:0] l_p_idx,
    output logic [IDX_W-1:0] g_p_idx,
    output logic [IDX_W-1:0] p_idx,
    output logic             bp_ready,
    input  logic             upd_valid,
    input  logic             upd_jump,
    input  logic             upd_taken,
    input  logic             upd_l_p_outcome,
    input  logic             upd_g_p_outcome,
    input  logic             upd_p_outcome,
    input  logic [IDX_W-1:0] upd_l_p_idx,
    input  logic [IDX_W-1:0] upd_g_p_idx,
    input  logic [IDX_W-1:0] upd_p_idx
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] sweep_reg;
    logic [IDX_W-1:0] ghr_reg;
    logic             running;
    logic             train_en;

    logic [1:0] local_tab   [DEPTH];
    logic [1:0] global_tab  [DEPTH];
    logic [1:0] chooser_tab [DEPTH];

    logic [1:0] local_rd;
    logic [1:0] global_rd;
    logic [1:0] chooser_rd;
    logic [1:0] local_next;
    logic [1:0] global_next;
    logic [1:0] chooser_next;
    logic       l_ok;
    logic       g_ok;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up, input logic dn);
        logic [1:0] res;
        res = ctr;
        if (up && ctr != 2'd3) begin
            res = ctr + 2'd1;
        end else if (dn && ctr != 2'd0) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: the sweep finishes on the cycle it writes the last entry
    always_comb begin
        state_next = state_reg;
        if (state_reg == CLEAR && sweep_reg == IDX_W'(DEPTH - 1)) begin
            state_next = RUN;
        end
    end

    // Output logic
    always_comb begin
        running  = (state_reg == RUN);
        bp_ready = running;
        train_en = running && upd_valid && !upd_jump;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_reg <= '0;
        end else if (state_reg == CLEAR) begin
            sweep_reg <= sweep_reg + 1'b1;
        end
    end

    // History is only shifted by resolved conditional branches, never speculatively
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (train_en) begin
            ghr_reg <= {ghr_reg[IDX_W-2:0], upd_taken};
        end
    end

    always_comb begin
        l_p_idx     = fetch_pc[IDX_W+1:2];
        g_p_idx     = fetch_pc[IDX_W+1:2] ^ ghr_reg;
        p_idx       = fetch_pc[IDX_W+1:2];
        local_rd    = local_tab[l_p_idx];
        global_rd   = global_tab[g_p_idx];
        chooser_rd  = chooser_tab[p_idx];
        l_p_outcome = running && local_rd[1];
        g_p_outcome = running && global_rd[1];
        p_outcome   = running && (chooser_rd[1] ? global_rd[1] : local_rd[1]);
    end

    always_comb begin
        l_ok         = (upd_l_p_outcome == upd_taken);
        g_ok         = (upd_g_p_outcome == upd_taken);
        local_next   = sat_step(local_tab[upd_l_p_idx], upd_taken, !upd_taken);
        global_next  = sat_step(global_tab[upd_g_p_idx], upd_taken, !upd_taken);
        chooser_next = sat_step(chooser_tab[upd_p_idx], g_ok && !l_ok, l_ok && !g_ok);
    end

    // Table storage carries no reset; the CLEAR sweep initialises every entry to weakly not-taken
    always_ff @(posedge clk) begin
        if (!running) begin
            local_tab[sweep_reg]   <= 2'b01;
            global_tab[sweep_reg]  <= 2'b01;
            chooser_tab[sweep_reg] <= 2'b01;
        end else if (train_en) begin
            local_tab[upd_l_p_idx]  <= local_next;
            global_tab[upd_g_p_idx] <= global_next;
            chooser_tab[upd_p_idx]  <= chooser_next;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (train_en) begin
            stat_branches <= stat_branches + 32'd1;
            if (upd_p_outcome != upd_taken) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0], upd_p_outcome};
`endif

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Self-checking bench for tournament_branch_predictor: directed scenarios plus randomized
// training checked against a table-level reference model.
module tb_tournament_branch_predictor;

    localparam int IDX_W = 10;
    localparam int DEPTH = 1 << IDX_W;
    localparam int MASK  = DEPTH - 1;

    logic             clk;
    logic             rst;
    logic [31:0]      fetch_pc;
    logic             l_p_outcome, g_p_outcome, p_outcome;
    logic [IDX_W-1:0] l_p_idx, g_p_idx, p_idx;
    logic             bp_ready;
    logic             upd_valid, upd_jump, upd_taken;
    logic             upd_l_p_outcome, upd_g_p_outcome, upd_p_outcome;
    logic [IDX_W-1:0] upd_l_p_idx, upd_g_p_idx, upd_p_idx;
`ifdef BP_STATS_EN
    logic [31:0]      stat_branches, stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: counter values as plain integers 0..3
    int m_local   [DEPTH];
    int m_global  [DEPTH];
    int m_chooser [DEPTH];
    int m_ghr;
    int m_branches;
    int m_mispredicts;

    tournament_branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .l_p_outcome     (l_p_outcome),
        .g_p_outcome     (g_p_outcome),
        .p_outcome       (p_outcome),
        .l_p_idx         (l_p_idx),
        .g_p_idx         (g_p_idx),
        .p_idx           (p_idx),
        .bp_ready        (bp_ready),
        .upd_valid       (upd_valid),
        .upd_jump        (upd_jump),
        .upd_taken       (upd_taken),
        .upd_l_p_outcome (upd_l_p_outcome),
        .upd_g_p_outcome (upd_g_p_outcome),
        .upd_p_outcome   (upd_p_outcome),
        .upd_l_p_idx     (upd_l_p_idx),
        .upd_g_p_idx     (upd_g_p_idx),
        .upd_p_idx       (upd_p_idx)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_local[i]   = 1;
            m_global[i]  = 1;
            m_chooser[i] = 1;
        end
        m_ghr         = 0;
        m_branches    = 0;
        m_mispredicts = 0;
    endtask

    function automatic int bump(input int v, input int delta);
        int r;
        r = v + delta;
        if (r > 3) r = 3;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic model_train(input bit t, input bit lo, input bit go, input bit po,
                               input int li, input int gi, input int pi);
        m_local[li]  = bump(m_local[li], t ? 1 : -1);
        m_global[gi] = bump(m_global[gi], t ? 1 : -1);
        if (go == t && lo != t) m_chooser[pi] = bump(m_chooser[pi], 1);
        else if (lo == t && go != t) m_chooser[pi] = bump(m_chooser[pi], -1);
        m_ghr = ((m_ghr * 2) + (t ? 1 : 0)) & MASK;
        m_branches++;
        if (po != t) m_mispredicts++;
    endtask

    // Drive one update for a single clock, mirroring it into the model at the edge
    task automatic apply(input bit v, input bit j, input bit t, input bit lo, input bit go,
                         input bit po, input int li, input int gi, input int pi);
        upd_valid = v; upd_jump = j; upd_taken = t;
        upd_l_p_outcome = lo; upd_g_p_outcome = go; upd_p_outcome = po;
        upd_l_p_idx = li[IDX_W-1:0]; upd_g_p_idx = gi[IDX_W-1:0]; upd_p_idx = pi[IDX_W-1:0];
        @(posedge clk);
        if (v && !j && bp_ready) model_train(t, lo, go, po, li, gi, pi);
        #1;
        upd_valid = 1'b0;
    endtask

    // Entered just after rst is released: expects exactly DEPTH cycles of CLEAR
    task automatic wait_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            total++;
            if (bp_ready !== 1'b0) begin
                bad++;
                $display("FAIL sweep_ready cycle=%0d got=%b exp=0", i, bp_ready);
            end
            total++;
            if (p_outcome !== 1'b0) begin
                bad++;
                $display("FAIL sweep_p_outcome cycle=%0d got=%b exp=0", i, p_outcome);
            end
            @(posedge clk);
        end
        #1;
        total++;
        if (bp_ready !== 1'b1) begin
            bad++;
            $display("FAIL sweep_done got=%b exp=1", bp_ready);
        end
    endtask

    task automatic reset_sweep();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_sweep();
    endtask

    task automatic test_reset();
        fetch_pc = 32'h0000_1234;
        rst = 1'b1;
        #2;
        total++;
        if (bp_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=0", bp_ready);
        end
        total++;
        if (g_p_idx !== 10'h08D) begin
            bad++;
            $display("FAIL reset_ghr_idx got=%h exp=08d", g_p_idx);
        end
        reset_sweep();
        for (int k = 0; k < 8; k++) begin
            fetch_pc = $urandom;
            #1;
            total++;
            if ({l_p_outcome, g_p_outcome, p_outcome} !== 3'b000) begin
                bad++;
                $display("FAIL cleared_outcomes pc=%h got=%b exp=000", fetch_pc,
                         {l_p_outcome, g_p_outcome, p_outcome});
            end
            total++;
            if (l_p_idx !== fetch_pc[11:2] || p_idx !== fetch_pc[11:2]) begin
                bad++;
                $display("FAIL cleared_idx pc=%h got=%h/%h exp=%h", fetch_pc, l_p_idx, p_idx,
                         fetch_pc[11:2]);
            end
            $display("clear check pc=%h l=%b g=%b p=%b", fetch_pc, l_p_outcome, g_p_outcome, p_outcome);
        end
    endtask

    task automatic test_local_saturation();
        bit exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit dir_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fetch_pc = 32'h0000_0010;
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b0, dir_seq[k], 1'b0, 1'b0, 1'b0, 4, 'h100, 'h100);
            total++;
            if (l_p_outcome !== exp_seq[k]) begin
                bad++;
                $display("FAIL local_sat step=%0d got=%b exp=%b", k, l_p_outcome, exp_seq[k]);
            end
            $display("local update %0d taken=%b l_p_outcome=%b", k, dir_seq[k], l_p_outcome);
        end
    endtask

    task automatic test_ghr();
        reset_sweep();
        fetch_pc = 32'h0000_0040;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 'h200, 'h200, 'h200);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 'h200, 'h200, 'h200);
        total++;
        if (g_p_idx !== 10'h013) begin
            bad++;
            $display("FAIL ghr_two_taken got=%h exp=013", g_p_idx);
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 'h200, 'h200, 'h200);
        total++;
        if (g_p_idx !== 10'h013) begin
            bad++;
            $display("FAIL ghr_jump got=%h exp=013", g_p_idx);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 'h200, 'h200, 'h200);
        total++;
        if (g_p_idx !== 10'h016) begin
            bad++;
            $display("FAIL ghr_not_taken got=%h exp=016", g_p_idx);
        end
        $display("ghr check g_p_idx=%h", g_p_idx);
    endtask

    task automatic test_chooser();
        reset_sweep();
        fetch_pc = 32'h0000_0080;
        // Global right, local wrong: chooser 01->10, lookup gshare index 0x21 was trained taken
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 'h3FF, 'h021, 'h020);
        total++;
        if ({l_p_outcome, g_p_outcome, p_outcome} !== 3'b011) begin
            bad++;
            $display("FAIL chooser_to_global got=%b exp=011", {l_p_outcome, g_p_outcome, p_outcome});
        end
        // Both right: chooser stays 10
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 'h3FF, 'h026, 'h020);
        // Local right, global wrong: chooser 10->01, selecting local again
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'h3FF, 'h3FE, 'h020);
        total++;
        if ({l_p_outcome, g_p_outcome, p_outcome} !== 3'b010) begin
            bad++;
            $display("FAIL chooser_back_local got=%b exp=010", {l_p_outcome, g_p_outcome, p_outcome});
        end
        $display("chooser check l=%b g=%b p=%b", l_p_outcome, g_p_outcome, p_outcome);
    endtask

    task automatic test_same_cycle();
        reset_sweep();
        fetch_pc = 32'h0000_0010;
        upd_valid = 1'b1; upd_jump = 1'b0; upd_taken = 1'b1;
        upd_l_p_outcome = 1'b0; upd_g_p_outcome = 1'b0; upd_p_outcome = 1'b0;
        upd_l_p_idx = 10'h004; upd_g_p_idx = 10'h100; upd_p_idx = 10'h100;
        @(negedge clk);
        total++;
        if (l_p_outcome !== 1'b0) begin
            bad++;
            $display("FAIL hazard_pre got=%b exp=0", l_p_outcome);
        end
        @(posedge clk);
        model_train(1'b1, 1'b0, 1'b0, 1'b0, 'h004, 'h100, 'h100);
        #1;
        upd_valid = 1'b0;
        total++;
        if (l_p_outcome !== 1'b1) begin
            bad++;
            $display("FAIL hazard_post got=%b exp=1", l_p_outcome);
        end
        $display("same-cycle check l_p_outcome=%b", l_p_outcome);
    endtask

    task automatic test_random();
        int idx, gidx, li, gi, pi;
        bit v, j, t, lo, go, po;
        bit el, eg, ep;
        for (int n = 0; n < 400; n++) begin
            fetch_pc = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            v = ($urandom_range(0, 3) != 0);
            j = ($urandom_range(0, 3) == 0);
            t = 1'($urandom); lo = 1'($urandom); go = 1'($urandom); po = 1'($urandom);
            li = $urandom_range(0, 15); gi = $urandom_range(0, 15); pi = $urandom_range(0, 15);
            upd_valid = v; upd_jump = j; upd_taken = t;
            upd_l_p_outcome = lo; upd_g_p_outcome = go; upd_p_outcome = po;
            upd_l_p_idx = li[IDX_W-1:0]; upd_g_p_idx = gi[IDX_W-1:0]; upd_p_idx = pi[IDX_W-1:0];
            idx  = (fetch_pc >> 2) & MASK;
            gidx = idx ^ m_ghr;
            el = (m_local[idx] >= 2);
            eg = (m_global[gidx] >= 2);
            ep = (m_chooser[idx] >= 2) ? eg : el;
            @(negedge clk);
            total++;
            if ({l_p_outcome, g_p_outcome, p_outcome} !== {el, eg, ep}) begin
                bad++;
                $display("FAIL rand_outcomes n=%0d got=%b exp=%b", n,
                         {l_p_outcome, g_p_outcome, p_outcome}, {el, eg, ep});
            end
            total++;
            if (int'(g_p_idx) !== gidx) begin
                bad++;
                $display("FAIL rand_g_idx n=%0d got=%h exp=%h", n, g_p_idx, gidx);
            end
`ifdef BP_STATS_EN
            total++;
            if (int'(stat_branches) !== m_branches || int'(stat_mispredicts) !== m_mispredicts) begin
                bad++;
                $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stat_branches,
                         stat_mispredicts, m_branches, m_mispredicts);
            end
`endif
            $display("rand %0d pc=%h upd v=%b j=%b t=%b l=%b g=%b p=%b", n, fetch_pc, v, j, t,
                     l_p_outcome, g_p_outcome, p_outcome);
            @(posedge clk);
            if (v && !j) model_train(t, lo, go, po, li, gi, pi);
            #1;
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit tk [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit pr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        // Reset in the middle of the sweep
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (bp_ready !== 1'b0) begin
            bad++;
            $display("FAIL midclear_ready got=%b exp=0", bp_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_sweep();
        // Train, then reset asynchronously during RUN
        fetch_pc = 32'h0000_0010;
        for (int k = 0; k < 4; k++) apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 'h004, 'h010, 'h004);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bp_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrun_ready got=%b exp=0", bp_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_sweep();
        total++;
        if ({l_p_outcome, g_p_outcome, p_outcome} !== 3'b000) begin
            bad++;
            $display("FAIL midrun_tables got=%b exp=000", {l_p_outcome, g_p_outcome, p_outcome});
        end
        $display("mid reset check ready=%b l=%b", bp_ready, l_p_outcome);
`ifdef BP_STATS_EN
        total++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b0, tk[k], 1'b0, 1'b0, pr[k], 'h001, 'h001, 'h001);
            apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 'h002, 'h002, 'h002);
        end
        total++;
        if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
            bad++;
            $display("FAIL stats_count got=%0d/%0d exp=5/2", stat_branches, stat_mispredicts);
        end
        $display("stats check branches=%0d mispredicts=%0d", stat_branches, stat_mispredicts);
`endif
    endtask

    initial begin
        rst = 1'b0;
        fetch_pc = 32'h0;
        upd_valid = 1'b0; upd_jump = 1'b0; upd_taken = 1'b0;
        upd_l_p_outcome = 1'b0; upd_g_p_outcome = 1'b0; upd_p_outcome = 1'b0;
        upd_l_p_idx = '0; upd_g_p_idx = '0; upd_p_idx = '0;
        model_reset();
        test_reset();
        test_local_saturation();
        test_ghr();
        test_chooser();
        test_same_cycle();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
